arith_div: RTL and testbench

Iterative restoring divider that supplies the division operator the combinational arithmetic block omits. It computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock. A start/busy/done handshake lets a controller or bench issue operations and collect results. It sits beside the combinational arithmetic unit and shares its operand naming and width.

---
 rtl/arith_div.sv | 133 +++++++++++++
 tb/tb_arith_div.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_div.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional macro ARITH_DIV_SIGNED_EN selects two's-complement operands (truncating division).
module arith_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_qNext;
  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic [WIDTH-1:0] w_qOut;
  logic [WIDTH-1:0] w_rOut;

  // Partial remainder stays below the divisor, so the shifted value is below 2*b and
  // the top bit of the WIDTH+1 bit difference is a reliable borrow indicator.
  assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_remNext = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_qNext   = {r_dvd[WIDTH-2:0], w_ge};

`ifdef ARITH_DIV_SIGNED_EN
  logic r_signQ;
  logic r_signR;

  // The most-negative operand's magnitude is still representable as an unsigned value.
  assign w_aMag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign w_bMag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign w_qOut = r_signQ ? (~w_qNext + WIDTH'(1)) : w_qNext;
  assign w_rOut = r_signR ? (~w_remNext + WIDTH'(1)) : w_remNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_signQ <= 1'b0;
      r_signR <= 1'b0;
    end else if ((r_state != S_CALC) && start) begin
      r_signQ <= a[WIDTH-1] ^ b[WIDTH-1];
      r_signR <= a[WIDTH-1];
    end
  end
`else
  assign w_aMag = a;
  assign w_bMag = b;
  assign w_qOut = w_qNext;
  assign w_rOut = w_remNext;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            if (b != '0) begin
              r_state <= S_CALC;
              busy    <= 1'b1;
              r_cnt   <= CW'(WIDTH - 1);
              r_rem   <= '0;
              r_dvd   <= w_aMag;
              r_div   <= w_bMag;
              dz      <= 1'b0;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
              q       <= '1;
              r       <= a;
              dz      <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_remNext;
          r_dvd <= w_qNext;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            q       <= w_qOut;
            r       <= w_rOut;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_div.sv
// Self-checking bench for arith_div: scoreboard of expected q/r/dz popped on each done pulse.
// Signed scenarios are exercised when ARITH_DIV_SIGNED_EN is defined.
module tb_arith_div;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sbQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  arith_div #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; optionally record the expected result.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input bit push);
    exp_t e;
    a     = ia;
    b     = ib;
    start = 1'b1;
    if (push) begin
      e.q  = eq;
      e.r  = er;
      e.dz = edz;
      sbQ.push_back(e);
    end
    step();
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = current cycle) on which done is seen and the busy count before it.
  task automatic wait_done(output int cycles, output int busyCnt, output bit seen);
    cycles  = 1;
    busyCnt = 0;
    seen    = 1'b0;
    while (!done && cycles < 30) begin
      if (busy) busyCnt++;
      step();
      cycles++;
    end
    seen = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    nCompared++;
    if ({q, r, busy, done, dz} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dz=%b, expected all 0", q, r, busy, done, dz);
    end
    rst_n = 1'b1;
    step();
    nCompared++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int cyc, bc;
    bit seen;
    exp_t e;
    issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    wait_done(cyc, bc, seen);
    nCompared++;
    if (!seen || cyc !== W + 1) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got done at cycle %0d (seen=%b), expected %0d", cyc, seen, W + 1);
    end
    nCompared++;
    if (bc !== W) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles, expected %0d", bc, W);
    end
    e = sbQ.pop_front();
    nCompared++;
    if (q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL basic_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      nCompared++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd4 || r !== 4'd1) begin
        nMismatched++;
        $display("[TB] FAIL basic_hold: got done=%b busy=%b q=%h r=%h, expected 0 0 4 1", done, busy, q, r);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc, bc;
    bit seen;
    exp_t e;
    issue(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1'b1);
    wait_done(cyc, bc, seen);
    nCompared++;
    if (!seen || cyc !== 1 || bc !== 0) begin
      nMismatched++;
      $display("[TB] FAIL dz_latency: got cycle %0d busy %0d (seen=%b), expected 1 0", cyc, bc, seen);
    end
    e = sbQ.pop_front();
    nCompared++;
    if (q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL dz_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    step();
    nCompared++;
    if (done !== 1'b0 || dz !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL dz_after: got done=%b dz=%b, expected 0 1", done, dz);
    end
    issue(4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 1'b1);
    wait_done(cyc, bc, seen);
    e = sbQ.pop_front();
    nCompared++;
    if (!seen || q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL dz_clear: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    step();
  endtask

  task automatic test_ignore_busy();
    int cyc, bc, extraDone, extraBusy;
    bit seen;
    exp_t e;
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
    step();
    a     = 4'd2;
    b     = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, bc, seen);
    nCompared++;
    if (!seen || cyc + 2 !== W + 1) begin
      nMismatched++;
      $display("[TB] FAIL ignore_latency: got done at cycle %0d (seen=%b), expected %0d", cyc + 2, seen, W + 1);
    end
    e = sbQ.pop_front();
    nCompared++;
    if (q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL ignore_result: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    extraDone = 0;
    extraBusy = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) extraDone++;
      if (busy) extraBusy++;
    end
    nCompared++;
    if (extraDone !== 0 || extraBusy !== 0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_no_second: got %0d done / %0d busy cycles, expected 0 0", extraDone, extraBusy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    bit seen;
    exp_t e;
    issue(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
    wait_done(cyc, bc, seen);
    e = sbQ.pop_front();
    nCompared++;
    if (!seen || q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    issue(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done(cyc, bc, seen);
    nCompared++;
    if (!seen || cyc !== W + 1) begin
      nMismatched++;
      $display("[TB] FAIL b2b_spacing: got second done %0d cycles after first (seen=%b), expected %0d", cyc, seen, W + 1);
    end
    e = sbQ.pop_front();
    nCompared++;
    if (q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc, spurious;
    bit seen;
    exp_t e;
    issue(4'd12, 4'd5, '0, '0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    nCompared++;
    if ({q, r, busy, done, dz} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL midrst_outputs: got q=%h r=%h busy=%b done=%b dz=%b, expected all 0", q, r, busy, done, dz);
    end
    rst_n    = 1'b1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) spurious++;
    end
    nCompared++;
    if (spurious !== 0) begin
      nMismatched++;
      $display("[TB] FAIL midrst_no_done: got %0d active cycles after abort, expected 0", spurious);
    end
    issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
    wait_done(cyc, bc, seen);
    e = sbQ.pop_front();
    nCompared++;
    if (!seen || q !== e.q || r !== e.r || dz !== e.dz) begin
      nMismatched++;
      $display("[TB] FAIL midrst_rerun: got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b", q, r, dz, e.q, e.r, e.dz);
    end
    step();
  endtask

  task automatic test_random_unsigned();
    int cyc, bc;
    bit seen;
    exp_t e;
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      if (rb == '0)
        issue(ra, rb, 4'hF, ra, 1'b1, 1'b1);
      else
        issue(ra, rb, ra / rb, ra % rb, 1'b0, 1'b1);
      wait_done(cyc, bc, seen);
      e = sbQ.pop_front();
      nCompared++;
      if (!seen || q !== e.q || r !== e.r || dz !== e.dz) begin
        nMismatched++;
        $display("[TB] FAIL rand_%0d (%0d/%0d): got q=%h r=%h dz=%b, expected q=%h r=%h dz=%b",
                 i, ra, rb, q, r, dz, e.q, e.r, e.dz);
      end
    end
    step();
  endtask

  task automatic test_signed();
    int cyc, bc;
    bit seen;
    exp_t e;
    logic [W-1:0] sa[4] = '{4'b1001, 4'b1000, 4'b0111, 4'b1000};
    logic [W-1:0] sb[4] = '{4'b0010, 4'b1111, 4'b1110, 4'b0000};
    logic [W-1:0] sq[4] = '{4'b1101, 4'b1000, 4'b1101, 4'b1111};
    logic [W-1:0] sr[4] = '{4'b1111, 4'b0000, 4'b0001, 4'b1000};
    logic         sd[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(sa[i], sb[i], sq[i], sr[i], sd[i], 1'b1);
      wait_done(cyc, bc, seen);
      e = sbQ.pop_front();
      nCompared++;
      if (!seen || q !== e.q || r !== e.r || dz !== e.dz) begin
        nMismatched++;
        $display("[TB] FAIL signed_%0d: got q=%b r=%b dz=%b, expected q=%b r=%b dz=%b", i, q, r, dz, e.q, e.r, e.dz);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
`ifdef ARITH_DIV_SIGNED_EN
    test_div_zero();
    test_reset_mid_op();
    test_signed();
`else
    test_basic();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_random_unsigned();
`endif
    nCompared++;
    if (sbQ.size() !== 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sbQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
